inst_loader: RTL and testbench
==============================

# inst_loader

Boot-time program loader that fills the instruction memory from a byte stream. It is the write side of the instruction-memory interface, where the fetch path is the read side. It accepts a length-prefixed byte stream through a valid/ready handshake and packs the bytes little-endian into 32-bit words. It issues one synchronous word write per word and holds the core in reset until the program is fully and validly loaded.

## Interface
- DEPTH, 16: instruction-memory depth in 32-bit words.
- ADDR_W, 4: word-address width; must equal clog2(DEPTH).
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse that begins a load.
- byte_in  in  8  stream byte.
- byte_valid  in  1  byte_in is valid.
- byte_ready  out  1  loader accepts a byte this cycle. A byte transfers when valid && ready.
- wr_en  out  1  one-cycle word write strobe to instruction memory.
- wr_addr  out  ADDR_W  word index being written.
- wr_data  out  32  assembled word.
- core_rst_n  out  1  active-low reset to the core; low while not loaded.
- done  out  1  program loaded; level signal.
- err  out  1  load failed; level signal.

## Operation
- Stream format: LEN_LO, LEN_HI (16-bit word count N, little-endian), then N×4 data bytes, little-endian per word (first byte goes to wr_data[7:0]). With checksum enabled, one trailing CHK byte follows.
- States: IDLE, LEN0, LEN1, DATA, CHK (only when checksum is enabled), DONE, ERR.
- IDLE/DONE/ERR, start=1 → LEN0. On this transition: clear done, err, word counter, byte counter and checksum; drive core_rst_n low.
- start in LEN0/LEN1/DATA/CHK is ignored.
- LEN0: a transfer latches the low byte of N → LEN1.
- LEN1: a transfer latches the high byte of N, then branches:
  - N > DEPTH → ERR.
  - N == 0 → DONE, or CHK when checksum is enabled.
  - otherwise → DATA.
- DATA: a 2-bit byte counter selects the byte lane. On the 4th byte of a word, the full word is registered into wr_data, wr_addr is set to the word counter, and wr_en is asserted for the next cycle. The word counter then increments.
- DATA exits after the write strobe of word N-1 has been issued. It goes to DONE (or CHK) on the cycle that wr_en is high.
- byte_ready is high in LEN0, LEN1, DATA and CHK. It is low in all other states, and also low in the cycle wr_en is high.
- DONE: done=1, core_rst_n=1.
- ERR: err=1, core_rst_n=0.
- A loader reset mid-load returns to IDLE. Memory may hold a partial image; the core stays in reset.

## Timing
- Reset values: byte_ready=0, wr_en=0, wr_addr=0, wr_data=0, core_rst_n=0, done=0, err=0. State is IDLE.
- start → byte_ready high on the next cycle.
- Accepting the 4th byte of a word at cycle t gives wr_en=1 at t+1, with wr_addr/wr_data stable. byte_ready=0 at t+1.
- Sustained throughput is 1 word per 5 cycles with byte_valid held high.
- done and core_rst_n rise in the cycle after the final wr_en (or after the CHK transfer). err rises in the cycle after the offending byte.
- All outputs are registered. There is no combinational path from any input to any output.

## Configuration
- INST_LOADER_CHECKSUM_EN defined:
  - The CHK state exists.
  - The running checksum is the XOR of every accepted byte, including LEN_LO and LEN_HI.
  - The CHK byte must equal that XOR. A match → DONE; a mismatch → ERR.
  - With N=0, CHK must equal LEN_LO^LEN_HI = 0x00.
- Undefined:
  - No CHK state and no checksum register.
  - err is set only for overlength.

## Structure
- inst_loader_pkg holds:
  - the state enum;
  - BYTES_PER_WORD=4;
  - LEN_W=16.
- Sub-module inst_byte_packer:
  - 2-bit lane counter and 32-bit shift/assemble register;
  - asserts word_valid when the 4th byte arrives;
  - cleared on start.
- The top level owns the FSM, the word counter, the write-port registers and the checksum.

## Test plan
- Reset, then idle: all outputs at reset values; start never pulsed → core_rst_n stays 0.
- Stream 02 00 | 13 00 00 00 | 93 00 10 00 (checksum off) → two writes:
  - wr_addr=0, wr_data=0x00000013;
  - wr_addr=1, wr_data=0x00100093;
  - then done=1, core_rst_n=1.
- Stream 11 00 with DEPTH=16 → err=1 after the second byte, no wr_en, core_rst_n=0.
- byte_valid toggled every other cycle during a 3-word load → identical writes at addresses 0..2, and no byte is accepted while wr_en=1.
- Checksum on, stream 01 00 | 13 00 00 00 | 12 → done. The same stream with 13 as the last byte → err.
- rst_n pulled low mid-DATA, then start followed by a full 1-word stream → clean reload, wr_addr=0, done=1.

Source files
------------

// File: rtl/inst_loader_pkg.sv
// Purpose: shared types and constants for the instruction-memory loader.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Config macro: INST_LOADER_CHECKSUM_EN adds the ST_CHK state.
package inst_loader_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int LEN_W          = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN0,
        ST_LEN1,
        ST_DATA,
`ifdef INST_LOADER_CHECKSUM_EN
        ST_CHK,
`endif
        ST_DONE,
        ST_ERR
    } state_e;

endpackage

// File: rtl/inst_byte_packer.sv
// Purpose: packs accepted stream bytes little-endian into 32-bit words.
// Latency: word_vld_o/word_dat_o are combinational on the 4th byte of a word.
// Backpressure: none; the caller only presents bytes it has accepted.
// Ports: clr_i resets the lane counter, byte_vld_i/byte_dat_i carry an
//        accepted byte, word_vld_o/word_dat_o present the completed word.
module inst_byte_packer
    import inst_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr_i,
    input  logic        byte_vld_i,
    input  logic [7:0]  byte_dat_i,
    output logic        word_vld_o,
    output logic [31:0] word_dat_o
);

    logic [1:0]  lane_q;
    // Only the first three bytes of a word need storage: the 4th byte is
    // merged straight from the input when the word completes. Bytes shift
    // in at the top so byte 0 ends up in bits [7:0].
    logic [23:0] asm_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane_q <= '0;
            asm_q  <= '0;
        end else if (clr_i) begin
            lane_q <= '0;
            asm_q  <= '0;
        end else if (byte_vld_i) begin
            lane_q <= lane_q + 2'd1;
            asm_q  <= {byte_dat_i, asm_q[23:8]};
        end
    end

    assign word_vld_o = byte_vld_i && (lane_q == 2'(BYTES_PER_WORD - 1));
    assign word_dat_o = {byte_dat_i, asm_q};

endmodule

// File: rtl/inst_loader.sv
// Purpose: boot loader filling instruction memory from a length-prefixed byte stream.
// Latency: word write strobe one cycle after its 4th byte; 1 word per 5 cycles sustained.
// Backpressure: byte_ready drops outside the load states and during each write strobe.
// Ports: start/byte_in/byte_valid/byte_ready form the stream side; wr_en/wr_addr/
//        wr_data drive the instruction-memory write port; core_rst_n, done, err
//        report load status. Config macro: INST_LOADER_CHECKSUM_EN adds a
//        trailing XOR checksum byte check.
module inst_loader
    import inst_loader_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              core_rst_n,
    output logic              done,
    output logic              err
);

    // State entered once all words (or zero words) have been written.
`ifdef INST_LOADER_CHECKSUM_EN
    localparam state_e ST_TAIL = ST_CHK;
`else
    localparam state_e ST_TAIL = ST_DONE;
`endif

    state_e              state_q, state_d;
    logic [7:0]          len_lo_q;
    logic [LEN_W-1:0]    len_q;
    logic [ADDR_W-1:0]   word_cnt_q;
    logic                rdy_q, rdy_d;
    logic                wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]   wr_addr_q;
    logic [31:0]         wr_data_q;
    logic                done_q, err_q, core_rst_n_q;
`ifdef INST_LOADER_CHECKSUM_EN
    logic [7:0]          chk_q;
`endif

    logic                accept;
    logic                clr;
    logic                last_word;
    logic [LEN_W-1:0]    len_in;
    logic                word_vld;
    logic [31:0]         word_dat;

    assign accept    = byte_valid && rdy_q;
    assign len_in    = {byte_in, len_lo_q};
    assign last_word = (LEN_W'(word_cnt_q) == (len_q - LEN_W'(1)));

    inst_byte_packer u_packer (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr_i      (clr),
        .byte_vld_i (accept && (state_q == ST_DATA)),
        .byte_dat_i (byte_in),
        .word_vld_o (word_vld),
        .word_dat_o (word_dat)
    );

    always_comb begin
        state_d = state_q;
        clr     = 1'b0;
        wr_en_d = 1'b0;
        rdy_d   = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) begin
                    state_d = ST_LEN0;
                    clr     = 1'b1;
                end
            end
            ST_LEN0: begin
                if (accept) state_d = ST_LEN1;
            end
            ST_LEN1: begin
                if (accept) begin
                    if (len_in > LEN_W'(DEPTH)) state_d = ST_ERR;
                    else if (len_in == '0)      state_d = ST_TAIL;
                    else                        state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                // Exit on the strobe cycle of the last word; ready is low
                // then, so no further byte can be taken in that cycle.
                if (wr_en_q && last_word) state_d = ST_TAIL;
                else if (word_vld)        wr_en_d = 1'b1;
            end
`ifdef INST_LOADER_CHECKSUM_EN
            ST_CHK: begin
                if (accept) state_d = (byte_in == chk_q) ? ST_DONE : ST_ERR;
            end
`endif
            default: state_d = ST_IDLE;
        endcase

        // Ready is registered from the next state so it has no input path.
        if ((state_d == ST_LEN0) || (state_d == ST_LEN1) || (state_d == ST_DATA))
            rdy_d = 1'b1;
`ifdef INST_LOADER_CHECKSUM_EN
        if (state_d == ST_CHK) rdy_d = 1'b1;
`endif
        if (wr_en_d) rdy_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            len_lo_q     <= '0;
            len_q        <= '0;
            word_cnt_q   <= '0;
            rdy_q        <= 1'b0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            core_rst_n_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            rdy_q        <= rdy_d;
            wr_en_q      <= wr_en_d;
            done_q       <= (state_d == ST_DONE);
            err_q        <= (state_d == ST_ERR);
            core_rst_n_q <= (state_d == ST_DONE);
            if (accept && (state_q == ST_LEN0)) len_lo_q <= byte_in;
            if (accept && (state_q == ST_LEN1)) len_q    <= len_in;
            if (clr)          word_cnt_q <= '0;
            else if (wr_en_q) word_cnt_q <= word_cnt_q + 1'b1;
            if (wr_en_d) begin
                wr_addr_q <= word_cnt_q;
                wr_data_q <= word_dat;
            end
        end
    end

`ifdef INST_LOADER_CHECKSUM_EN
    // Running XOR over every accepted byte, length bytes included.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      chk_q <= '0;
        else if (clr)    chk_q <= '0;
        else if (accept) chk_q <= chk_q ^ byte_in;
    end
`endif

    assign byte_ready = rdy_q;
    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign core_rst_n = core_rst_n_q;
    assign done       = done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_inst_loader.sv
// Purpose: self-checking bench for inst_loader (table vectors plus directed sequences).
// Latency: n/a.
// Backpressure: drives byte_valid with and without idle gaps.
module tb_inst_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  byte_in = 8'h00;
    logic        byte_valid = 1'b0;
    logic        byte_ready;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [31:0] wr_data;
    logic        core_rst_n;
    logic        done;
    logic        err;

    inst_loader #(.DEPTH(16), .ADDR_W(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .core_rst_n (core_rst_n),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Write-port monitor, sampled on the falling edge.
    logic [3:0]  wq_addr[$];
    logic [31:0] wq_data[$];
    int          rdy_bad = 0;
    always @(negedge clk) begin
        if (wr_en) begin
            wq_addr.push_back(wr_addr);
            wq_data.push_back(wr_data);
            if (byte_ready) rdy_bad++;
        end
    end

    typedef struct {
        logic        st;
        logic        vld;
        logic [7:0]  b;
        logic        rdy;
        logic        we;
        logic [3:0]  addr;
        logic [31:0] data;
        logic        dn;
        logic        er;
        logic        crn;
    } vec_t;
    vec_t tbl[$];

    task automatic add(input logic st, input logic vld, input logic [7:0] b,
                       input logic rdy, input logic we, input logic [3:0] addr,
                       input logic [31:0] data, input logic dn, input logic er,
                       input logic crn);
        vec_t v;
        v.st = st; v.vld = vld; v.b = b; v.rdy = rdy; v.we = we; v.addr = addr;
        v.data = data; v.dn = dn; v.er = er; v.crn = crn;
        tbl.push_back(v);
    endtask

    logic [31:0] wbuf [0:15];
    logic [7:0]  sq[$];

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Offer one byte and return on the falling edge after it transfers.
    task automatic send(input logic [7:0] b, input int gap);
        int n;
        n = 0;
        byte_in    = b;
        byte_valid = 1'b1;
        while (!byte_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!byte_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: byte 0x%0h never accepted", b);
        end
        @(negedge clk);
        byte_valid = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic send_list(input int gap);
        foreach (sq[i]) send(sq[i], gap);
    endtask

    // Build a complete stream of nw words from wbuf and send it after start.
    task automatic load(input int nw, input int gap);
        sq.delete();
        sq.push_back(8'(nw));
        sq.push_back(8'(nw >> 8));
        for (int w = 0; w < nw; w++)
            for (int k = 0; k < 4; k++) sq.push_back(wbuf[w][8*k +: 8]);
`ifdef INST_LOADER_CHECKSUM_EN
        begin
            logic [7:0] x;
            x = 8'h00;
            foreach (sq[i]) x ^= sq[i];
            sq.push_back(x);
        end
`endif
        pulse_start();
        send_list(gap);
    endtask

    task automatic wait_end(input string name, input int lim);
        int n;
        n = 0;
        while (!done && !err && n < lim) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (!done && !err) begin
            n_fail++;
            $display("FAIL %s: timeout, got done=0 err=0, required done or err", name);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---------------- reset and idle ----------------
        @(negedge clk);
        check("rst_ready", byte_ready, 0);
        check("rst_wr_en", wr_en, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_wr_data", wr_data, 0);
        check("rst_core_rst_n", core_rst_n, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check($sformatf("idle_core_rst_n_%0d", i), core_rst_n, 0);
            check($sformatf("idle_ready_%0d", i), byte_ready, 0);
        end

        // ---------------- table: 2-word load ----------------
        //   st vld byte   rdy we a  data          dn er crn
        add(1, 0, 8'h00,  0, 0, 0, 32'h0,        0, 0, 0);
        add(0, 1, 8'h02,  1, 0, 0, 32'h0,        0, 0, 0);
        add(0, 1, 8'h00,  1, 0, 0, 32'h0,        0, 0, 0);
        add(0, 1, 8'h13,  1, 0, 0, 32'h0,        0, 0, 0);
        add(0, 1, 8'h00,  1, 0, 0, 32'h0,        0, 0, 0);
        add(0, 1, 8'h00,  1, 0, 0, 32'h0,        0, 0, 0);
        add(0, 1, 8'h00,  1, 0, 0, 32'h0,        0, 0, 0);
        add(0, 1, 8'h93,  0, 1, 0, 32'h13,       0, 0, 0);
        add(0, 1, 8'h93,  1, 0, 0, 32'h13,       0, 0, 0);
        add(0, 1, 8'h00,  1, 0, 0, 32'h13,       0, 0, 0);
        add(0, 1, 8'h10,  1, 0, 0, 32'h13,       0, 0, 0);
        add(0, 1, 8'h00,  1, 0, 0, 32'h13,       0, 0, 0);
`ifdef INST_LOADER_CHECKSUM_EN
        // 02^00^13^93^10 = 0x92
        add(0, 1, 8'h92,  0, 1, 1, 32'h00100093, 0, 0, 0);
        add(0, 1, 8'h92,  1, 0, 1, 32'h00100093, 0, 0, 0);
        add(0, 0, 8'h00,  0, 0, 1, 32'h00100093, 1, 0, 1);
        add(0, 0, 8'h00,  0, 0, 1, 32'h00100093, 1, 0, 1);
`else
        add(0, 0, 8'h00,  0, 1, 1, 32'h00100093, 0, 0, 0);
        add(0, 0, 8'h00,  0, 0, 1, 32'h00100093, 1, 0, 1);
        add(0, 0, 8'h00,  0, 0, 1, 32'h00100093, 1, 0, 1);
`endif
        foreach (tbl[i]) begin
            @(negedge clk);
            check($sformatf("tbl%0d_ready", i), byte_ready, tbl[i].rdy);
            check($sformatf("tbl%0d_wr_en", i), wr_en, tbl[i].we);
            check($sformatf("tbl%0d_wr_addr", i), wr_addr, tbl[i].addr);
            check($sformatf("tbl%0d_wr_data", i), wr_data, tbl[i].data);
            check($sformatf("tbl%0d_done", i), done, tbl[i].dn);
            check($sformatf("tbl%0d_err", i), err, tbl[i].er);
            check($sformatf("tbl%0d_core_rst_n", i), core_rst_n, tbl[i].crn);
            start      = tbl[i].st;
            byte_valid = tbl[i].vld;
            byte_in    = tbl[i].b;
        end
        start = 1'b0;
        byte_valid = 1'b0;

        // ---------------- overlength N=17 ----------------
        @(negedge clk);
        wq_addr.delete();
        wq_data.delete();
        pulse_start();
        check("start_to_ready", byte_ready, 1);
        check("start_clears_done", done, 0);
        send(8'h11, 0);
        send(8'h00, 0);
        check("ovl_err", err, 1);
        check("ovl_done", done, 0);
        check("ovl_core_rst_n", core_rst_n, 0);
        check("ovl_ready", byte_ready, 0);
        repeat (3) @(negedge clk);
        check("ovl_no_writes", wq_addr.size(), 0);

        // ---------------- 3-word load, valid toggling ----------------
        wbuf[0] = 32'h11223344;
        wbuf[1] = 32'hDEADBEEF;
        wbuf[2] = 32'h00C0FFEE;
        wq_addr.delete();
        wq_data.delete();
        rdy_bad = 0;
        load(3, 1);
        wait_end("tog_end", 50);
        check("tog_done", done, 1);
        check("tog_err", err, 0);
        check("tog_core_rst_n", core_rst_n, 1);
        repeat (2) @(negedge clk);
        check("tog_nwrites", wq_addr.size(), 3);
        for (int i = 0; i < 3; i++) begin
            if (i < wq_addr.size()) begin
                check($sformatf("tog_addr%0d", i), wq_addr[i], i);
                check($sformatf("tog_data%0d", i), wq_data[i], wbuf[i]);
            end
        end
        check("tog_ready_low_during_wr", rdy_bad, 0);

        // ---------------- zero-length program ----------------
        wq_addr.delete();
        wq_data.delete();
        load(0, 0);
        wait_end("zero_end", 20);
        check("zero_done", done, 1);
        check("zero_err", err, 0);
        check("zero_no_writes", wq_addr.size(), 0);

`ifdef INST_LOADER_CHECKSUM_EN
        // ---------------- checksum match / mismatch ----------------
        sq = '{8'h01, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h12};
        pulse_start();
        send_list(0);
        check("chk_good_done", done, 1);
        check("chk_good_err", err, 0);
        sq = '{8'h01, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h13};
        pulse_start();
        send_list(0);
        check("chk_bad_err", err, 1);
        check("chk_bad_done", done, 0);
        check("chk_bad_core_rst_n", core_rst_n, 0);
`endif

        // ---------------- reset mid-DATA, then reload ----------------
        pulse_start();
        send(8'h01, 0);
        send(8'h00, 0);
        send(8'h37, 0);
        send(8'h12, 0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_ready", byte_ready, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_core_rst_n", core_rst_n, 0);
        check("mid_rst_wr_en", wr_en, 0);
        @(negedge clk);
        rst_n = 1'b1;
        wq_addr.delete();
        wq_data.delete();
        wbuf[0] = 32'h00001237;
        load(1, 0);
        wait_end("reload_end", 20);
        check("reload_done", done, 1);
        check("reload_core_rst_n", core_rst_n, 1);
        repeat (2) @(negedge clk);
        check("reload_nwrites", wq_addr.size(), 1);
        if (wq_addr.size() > 0) begin
            check("reload_addr", wq_addr[0], 0);
            check("reload_data", wq_data[0], 32'h00001237);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
